// File: rtl/ibuf_fill_ctrl.sv
// ibuf_fill_ctrl: input-buffer fill sequencer.
// Accepts one tile of DDR beats over valid/ready and regroups each beat into bank-major order.
// Writes each regrouped beat to all banks at a linearly incrementing address.
// Signals completion to the tile scheduler when the tile is finished.
// Optional feature macro: IBUF_FILL_PERF_CNT_EN enables the stall_cycles performance counter.
module ibuf_fill_ctrl #(
    parameter int unsigned DDR_BANDWIDTH = 512,
    parameter int unsigned NUM_BANKS     = 8,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter int unsigned BEATS_W       = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_WIDTH-1:0]    base_addr,
    input  logic [BEATS_W-1:0]       num_beats,
    output logic                     busy,
    output logic                     done,
    input  logic [DDR_BANDWIDTH-1:0] ddr_data,
    input  logic                     ddr_valid,
    output logic                     ddr_ready,
    output logic [NUM_BANKS-1:0]     bank_wr_en,
    output logic [ADDR_WIDTH-1:0]    bank_wr_addr,
    output logic [DDR_BANDWIDTH-1:0] bank_wr_data,
    output logic [BEATS_W-1:0]       stall_cycles
);

    localparam int unsigned RATIO = DDR_BANDWIDTH / (NUM_BANKS * DATA_WIDTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]               state_q, state_d;
    logic [ADDR_WIDTH-1:0]    base_q;
    logic [ADDR_WIDTH-1:0]    offset_q;
    logic [BEATS_W-1:0]       remaining_q;
    logic                     wr_en_q;
    logic [ADDR_WIDTH-1:0]    wr_addr_q;
    logic [DDR_BANDWIDTH-1:0] wr_data_q;
    logic [DDR_BANDWIDTH-1:0] shuffled;
    logic                     start_acc;
    logic                     accept;

    assign start_acc    = (state_q == ST_IDLE) && start;
    assign ddr_ready    = (state_q == ST_FILL) && (remaining_q != '0);
    assign accept       = ddr_valid && ddr_ready;
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign bank_wr_en   = {NUM_BANKS{wr_en_q}};
    assign bank_wr_addr = wr_addr_q;
    assign bank_wr_data = wr_data_q;

    // Bank-major regroup: element k of bank j moves from slot k*NUM_BANKS+j to slot j*RATIO+k
    always_comb begin
        shuffled = '0;
        for (int unsigned j = 0; j < NUM_BANKS; j++) begin
            for (int unsigned k = 0; k < RATIO; k++) begin
                shuffled[(j*RATIO+k)*DATA_WIDTH +: DATA_WIDTH] =
                    ddr_data[(k*NUM_BANKS+j)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = (num_beats != '0) ? ST_FILL : ST_DONE;
            ST_FILL:  if (accept && (remaining_q == BEATS_W'(1))) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Tile counters and the one-deep bank write register
    always_ff @(posedge clk) begin
        if (reset) begin
            base_q      <= '0;
            offset_q    <= '0;
            remaining_q <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            if (start_acc) begin
                base_q      <= base_addr;
                offset_q    <= '0;
                remaining_q <= num_beats;
            end else if (accept) begin
                offset_q    <= offset_q + ADDR_WIDTH'(1);
                remaining_q <= remaining_q - BEATS_W'(1);
            end
            wr_en_q <= accept;
            if (accept) begin
                wr_addr_q <= base_q + offset_q;
                wr_data_q <= shuffled;
            end
        end
    end

`ifdef IBUF_FILL_PERF_CNT_EN
    logic [BEATS_W-1:0] stall_q;

    // Saturating count of FILL cycles where the controller was ready but no beat arrived
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (start_acc) begin
            stall_q <= '0;
        end else if (ddr_ready && !ddr_valid && (stall_q != '1)) begin
            stall_q <= stall_q + BEATS_W'(1);
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_ibuf_fill_ctrl.sv
// Testbench for ibuf_fill_ctrl: directed tiles with a write scoreboard.
module tb_ibuf_fill_ctrl;

    localparam int unsigned DDR_BW = 512;
    localparam int unsigned NB     = 8;
    localparam int unsigned DW     = 8;
    localparam int unsigned AW     = 10;
    localparam int unsigned BW     = 16;
    localparam int unsigned NELEM  = DDR_BW / DW;
    localparam int unsigned RAT    = DDR_BW / (NB * DW);

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [AW-1:0]     base_addr;
    logic [BW-1:0]     num_beats;
    logic              busy;
    logic              done;
    logic [DDR_BW-1:0] ddr_data;
    logic              ddr_valid;
    logic              ddr_ready;
    logic [NB-1:0]     bank_wr_en;
    logic [AW-1:0]     bank_wr_addr;
    logic [DDR_BW-1:0] bank_wr_data;
    logic [BW-1:0]     stall_cycles;

    ibuf_fill_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .num_beats    (num_beats),
        .busy         (busy),
        .done         (done),
        .ddr_data     (ddr_data),
        .ddr_valid    (ddr_valid),
        .ddr_ready    (ddr_ready),
        .bank_wr_en   (bank_wr_en),
        .bank_wr_addr (bank_wr_addr),
        .bank_wr_data (bank_wr_data),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned       cyc;
        logic [AW-1:0]     addr;
        logic [DDR_BW-1:0] data;
    } exp_t;

    exp_t              sb[$];
    int                checks   = 0;
    int                failures = 0;
    int unsigned       cyc      = 0;
    int                done_cnt = 0;
    bit                mon_en   = 1'b0;
    logic [AW-1:0]     exp_addr;
    int                stalls;
    logic [DDR_BW-1:0] beat_data;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [DDR_BW-1:0] obs, input logic [DDR_BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference regroup: input element i belongs to bank i%NB, element i/NB of that bank
    function automatic logic [DDR_BW-1:0] shuffle(input logic [DDR_BW-1:0] d);
        logic [DDR_BW-1:0] r;
        r = '0;
        for (int i = 0; i < NELEM; i++)
            r[((i % NB) * RAT + i / NB) * DW +: DW] = d[i * DW +: DW];
        return r;
    endfunction

    function automatic logic [BW-1:0] exp_stall();
`ifdef IBUF_FILL_PERF_CNT_EN
        return BW'(stalls);
`else
        return '0;
`endif
    endfunction

    // Write monitor: every bank write must match the oldest pending accept, one cycle later
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (done === 1'b1) done_cnt++;
            if (bank_wr_en !== '0) begin
                check("wr_en_full", bank_wr_en, {NB{1'b1}});
                if (sb.size() == 0) begin
                    check("wr_unexpected", bank_wr_en, '0);
                end else begin
                    e = sb.pop_front();
                    check("wr_latency", cyc, e.cyc + 1);
                    check("wr_addr", bank_wr_addr, e.addr);
                    check("wr_data", bank_wr_data, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] base, input logic [BW-1:0] nb);
        start     = 1'b1;
        base_addr = base;
        num_beats = nb;
        tick();
        start     = 1'b0;
        base_addr = AW'($urandom);
        num_beats = BW'($urandom);
        exp_addr  = base;
        stalls    = 0;
    endtask

    // One FILL cycle: optional beat, optional stray start pulse
    task automatic beat_cycle(input bit v, input bit st, input bit counting);
        ddr_valid = v;
        start     = st;
        if (st) begin
            base_addr = AW'($urandom);
            num_beats = BW'(1);
        end
        if (counting) begin
            for (int i = 0; i < NELEM; i++) beat_data[i*DW +: DW] = DW'(i);
        end else begin
            for (int w = 0; w < DDR_BW / 32; w++) beat_data[w*32 +: 32] = $urandom;
        end
        ddr_data = beat_data;
        @(negedge clk);
        check("ready_fill", ddr_ready, 1'b1);
        check("busy_fill", busy, 1'b1);
        check("done_fill", done, 1'b0);
        if (v) begin
            exp_t e;
            e.cyc  = cyc;
            e.addr = exp_addr;
            e.data = shuffle(beat_data);
            sb.push_back(e);
            exp_addr = exp_addr + AW'(1);
        end else begin
            stalls++;
        end
        tick();
        ddr_valid = 1'b0;
        start     = 1'b0;
    endtask

    // Cycles L+1 .. L+3 after the last accept
    task automatic finish_tile();
        int d0;
        d0 = done_cnt;
        @(negedge clk);
        check("ready_drain", ddr_ready, 1'b0);
        check("busy_drain", busy, 1'b1);
        check("done_drain", done, 1'b0);
        tick();
        @(negedge clk);
        check("done_pulse", done, 1'b1);
        check("busy_done", busy, 1'b1);
        check("stall_at_done", stall_cycles, exp_stall());
        tick();
        @(negedge clk);
        check("busy_idle", busy, 1'b0);
        check("done_idle", done, 1'b0);
        check("ready_idle", ddr_ready, 1'b0);
        check("stall_hold", stall_cycles, exp_stall());
        check("done_count", done_cnt, d0 + 1);
        check("sb_empty", sb.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_ready"}, ddr_ready, 1'b0);
        check({tag, "_wr_en"}, bank_wr_en, '0);
        check({tag, "_wr_addr"}, bank_wr_addr, '0);
        check({tag, "_wr_data"}, bank_wr_data, '0);
        check({tag, "_stall"}, stall_cycles, '0);
    endtask

    initial begin
        int d0;
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        num_beats = '0;
        ddr_valid = 1'b0;
        ddr_data  = '0;
        beat_data = '0;
        exp_addr  = '0;
        stalls    = 0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_all_zero("reset");
        mon_en = 1'b1;
        reset  = 1'b0;
        tick();

        // Tile 1: four back-to-back beats, counting byte pattern
        do_start(AW'('h010), BW'(4));
        for (int b = 0; b < 4; b++) beat_cycle(1'b1, 1'b0, 1'b1);
        finish_tile();

        // Empty tile: straight to done, no writes, never ready
        do_start(AW'('h155), BW'(0));
        @(negedge clk);
        check("nb0_done", done, 1'b1);
        check("nb0_busy", busy, 1'b1);
        check("nb0_ready", ddr_ready, 1'b0);
        tick();
        @(negedge clk);
        check("nb0_idle_busy", busy, 1'b0);
        check("nb0_idle_done", done, 1'b0);
        check("nb0_stall", stall_cycles, '0);

        // Address wrap at the top of the bank
        do_start(AW'('h3FE), BW'(3));
        for (int b = 0; b < 3; b++) beat_cycle(1'b1, 1'b0, 1'b0);
        finish_tile();

        // Gapped valid pattern 1,0,0,1,0,1
        do_start(AW'('h020), BW'(3));
        beat_cycle(1'b1, 1'b0, 1'b0);
        beat_cycle(1'b0, 1'b0, 1'b0);
        beat_cycle(1'b0, 1'b0, 1'b0);
        beat_cycle(1'b1, 1'b0, 1'b0);
        beat_cycle(1'b0, 1'b0, 1'b0);
        beat_cycle(1'b1, 1'b0, 1'b0);
        finish_tile();

        // Stray start pulses while busy must be ignored
        do_start(AW'('h100), BW'(5));
        beat_cycle(1'b1, 1'b0, 1'b0);
        beat_cycle(1'b1, 1'b1, 1'b0);
        beat_cycle(1'b0, 1'b1, 1'b0);
        beat_cycle(1'b1, 1'b0, 1'b0);
        beat_cycle(1'b1, 1'b1, 1'b0);
        beat_cycle(1'b1, 1'b0, 1'b0);
        finish_tile();

        // Reset one cycle after the second accept aborts the tile
        do_start(AW'('h200), BW'(6));
        beat_cycle(1'b1, 1'b0, 1'b0);
        beat_cycle(1'b1, 1'b0, 1'b0);
        d0    = done_cnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("abort");
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            check("abort_busy", busy, 1'b0);
            check("abort_wr_en", bank_wr_en, '0);
        end
        check("abort_no_done", done_cnt, d0);
        check("abort_sb_empty", sb.size(), 0);

        // Recovery tile
        do_start(AW'('h040), BW'(2));
        beat_cycle(1'b1, 1'b0, 1'b0);
        beat_cycle(1'b1, 1'b0, 1'b0);
        finish_tile();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ibuf_fill_ctrl.md
# ibuf_fill_ctrl

Sequencing controller for the input-buffer fill path. Accepts one tile of DDR beats over a valid/ready handshake and applies the bank-major shuffle: the interleaved DDR word is regrouped so each bank receives a contiguous slice. Issues one registered write per beat to all NUM_BANKS input-buffer banks at a linearly incrementing address, then reports completion to the tile scheduler.

## Interface
- DDR_BANDWIDTH, 512, DDR beat width in bits
- NUM_BANKS, 8, number of input-buffer banks
- DATA_WIDTH, 8, element width in bits
- RATIO, DDR_BANDWIDTH/(NUM_BANKS*DATA_WIDTH), elements per bank per beat (derived; must be integer ≥1)
- ADDR_WIDTH, 10, bank address width
- BEATS_W, 16, width of the tile beat count
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle tile request; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first bank address of the tile; captured with start
- num_beats  in  BEATS_W  beats in the tile; captured with start
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at tile completion
- ddr_data  in  DDR_BANDWIDTH  DDR beat, element k of bank j at bit offset (k*NUM_BANKS+j)*DATA_WIDTH
- ddr_valid  in  1  beat valid
- ddr_ready  out  1  controller accepts beat
- bank_wr_en  out  NUM_BANKS  per-bank write strobe
- bank_wr_addr  out  ADDR_WIDTH  shared write address
- bank_wr_data  out  DDR_BANDWIDTH  shuffled data; bank j uses bits [(j+1)*RATIO*DATA_WIDTH-1 : j*RATIO*DATA_WIDTH], element k of bank j at offset (j*RATIO+k)*DATA_WIDTH within the bus
- stall_cycles  out  BEATS_W  count of FILL cycles with ddr_valid low (see Configuration)

## Operation
- States: IDLE, FILL, DRAIN, DONE.
- IDLE: start=1 captures base_addr and num_beats into registers and clears the write-address counter and beat counter. Next state is FILL if num_beats≠0, else DONE (no writes issued).
- FILL: ddr_ready = (remaining≠0). Accept = ddr_valid & ddr_ready. Each accept latches shuffled ddr_data and the current address into the write register, increments the address, and decrements remaining. Accepting the last beat moves the FSM to DRAIN.
- DRAIN: the last write is presented. Always one cycle, then DONE.
- DONE: done=1 for one cycle, then IDLE.
- start is ignored outside IDLE. ddr_valid is ignored outside FILL.
- Address arithmetic is modulo 2^ADDR_WIDTH: base_addr=2^ADDR_WIDTH-1 wraps to 0 on the next beat. No error is raised.
- The bank write path has no backpressure; a write is never dropped or delayed.
- bank_wr_en is all-ones or all-zeros; it is never partial.
- Reset values: state IDLE, busy=0, done=0, ddr_ready=0, bank_wr_en=0, bank_wr_addr=0, bank_wr_data=0, stall_cycles=0.
- Reset mid-tile aborts the tile. The write register clears, so a pending write is not issued, and no done pulse is produced.

## Timing
- start at cycle T: busy=1 and ddr_ready=1 at T+1 (when num_beats≠0).
- num_beats=0: done=1 at T+1, busy=1 only at T+1, IDLE at T+2.
- Accept at cycle k: bank_wr_en=all-ones at k+1 with bank_wr_addr=base_addr+index, where index is the 0-based beat index. Write latency is 1 cycle.
- Back-to-back accepts give back-to-back writes, so throughput is 1 beat/cycle.
- Last accept at L: ddr_ready=0 at L+1, DRAIN plus last write at L+1, done=1 at L+2, IDLE at L+3.
- Earliest next start is sampled at L+3.

## Configuration
- IBUF_FILL_PERF_CNT_EN defined: stall_cycles clears on an accepted start and increments each FILL cycle with ddr_ready=1 and ddr_valid=0. The count saturates at all-ones and holds its value after done until the next start.
- IBUF_FILL_PERF_CNT_EN undefined: no counter logic; stall_cycles is tied to 0.

## Test plan
- Reset, then start, base_addr=0x010, num_beats=4, ddr_valid held high, ddr_data[i*8+:8]=i for each beat. Expect writes at 0x010..0x013 on 4 consecutive cycles. Bank 0 slice bytes are 0,8,16,...,56; bank 1 slice bytes are 1,9,...,57. done occurs 2 cycles after the last accept.
- num_beats=0: done at T+1, bank_wr_en never asserted, ddr_ready never asserted.
- base_addr=0x3FE, num_beats=3, ADDR_WIDTH=10: write addresses 0x3FE, 0x3FF, 0x000.
- ddr_valid toggled 1,0,0,1,0,1 for num_beats=3: exactly 3 writes, each 1 cycle after its accept. With IBUF_FILL_PERF_CNT_EN, stall_cycles=3 at done.
- start pulsed again while busy during a num_beats=5 tile: ignored, exactly 5 writes and one done pulse.
- reset asserted 1 cycle after the second accept of a num_beats=6 tile: all outputs 0 next cycle, no done. A subsequent tile with num_beats=2 completes normally.
